// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: one-outstanding request/response fetch from instruction
// memory into a single-entry IF/ID output buffer, with redirect and stall handling.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_data,
  output logic        if_id_wr_en
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        discard_reg, discard_next;
  logic        valid_reg, valid_next;
  logic [31:0] insn_reg, insn_next;
  logic [31:0] pcd_reg, pcd_next;

  logic        handshake;
  logic        capture;
  logic [31:0] redirect_target;
  logic        redirect_lsb_unused;

  // Targets are forced to word alignment; the low bits carry no meaning here.
  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_REQ;
      pc_reg      <= RESET_PC;
      discard_reg <= 1'b0;
      valid_reg   <= 1'b0;
      insn_reg    <= NOP_INSN;
      pcd_reg     <= 32'h0000_0000;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      discard_reg <= discard_next;
      valid_reg   <= valid_next;
      insn_reg    <= insn_next;
      pcd_reg     <= pcd_next;
    end
  end

  // Next-state, pc and request generation.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    discard_next = discard_reg;
    imem_req     = 1'b0;
    handshake    = 1'b0;
    capture      = 1'b0;

    case (state_reg)
      ST_REQ: begin
        // Only ask for a word when the buffer is empty or drains this cycle.
        imem_req  = reset_n & (~valid_reg | ~stall);
        handshake = imem_req & imem_ready;
        if (handshake) begin
          state_next   = ST_WAIT;
          discard_next = redirect_en;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_next   = ST_REQ;
          discard_next = 1'b0;
          capture      = ~discard_reg & ~redirect_en;
          if (capture) begin
            pc_next = pc_reg + 32'd4;
          end
        end else if (redirect_en) begin
          discard_next = 1'b1;
        end
      end
    endcase

    // A redirect wins over sequential advance in every state.
    if (redirect_en) begin
      pc_next = redirect_target;
    end
  end

  // Output buffer: redirect flushes, capture fills, unstalled consume empties.
  always_comb begin
    valid_next = valid_reg;
    insn_next  = insn_reg;
    pcd_next   = pcd_reg;

    if (redirect_en) begin
      valid_next = 1'b0;
      insn_next  = NOP_INSN;
    end else if (capture) begin
      valid_next = 1'b1;
      insn_next  = imem_rdata;
      pcd_next   = pc_reg;
    end else if (valid_reg && !stall) begin
      valid_next = 1'b0;
      insn_next  = NOP_INSN;
    end
  end

  assign imem_addr   = pc_reg;
  assign if_valid    = valid_reg;
  assign instruction = insn_reg;
  assign pc_data     = pcd_reg;
  assign if_id_wr_en = ~stall;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013: bubble instruction word (addi x0,x0,0).
REQ-003 clk  in  1: single clock; all state updates on posedge.
REQ-004 reset_n  in  1: reset is asynchronous and active-low.
REQ-005 stall  in  1: decode-side hold; 1 = IF/ID must not be written this cycle.
REQ-006 redirect_en  in  1: branch/jump taken; redirect fetch this cycle.
REQ-007 redirect_pc  in  32: redirect target; bits [1:0] SHALL be treated as 00.
REQ-008 imem_req  out  1: fetch request valid.
REQ-009 imem_addr  out  32: fetch address, word aligned.
REQ-010 imem_ready  in  1: memory accepts request (handshake = imem_req & imem_ready).
REQ-011 imem_rvalid  in  1: response valid, one per accepted request, in order.
REQ-012 imem_rdata  in  32: response instruction word.
REQ-013 if_valid  out  1: instruction/pc_data hold a real fetched instruction.
REQ-014 instruction  out  32: fetched word; NOP_INSN when if_valid=0.
REQ-015 pc_data  out  32: address of instruction.
REQ-016 if_id_wr_en  out  1: write enable for downstream IF/ID register; SHALL equal !stall.

Function
REQ-017 FSM states: REQ (request outstanding-free, driving imem_req), WAIT (one request accepted, awaiting response); at most one request outstanding.
REQ-018 State REQ: imem_req = !if_valid | !stall (output buffer empty or consumed this cycle); imem_addr = pc; handshake -> WAIT.
REQ-019 State WAIT: imem_req=0; on imem_rvalid with discard=0: instruction<=imem_rdata, pc_data<=pc, if_valid<=1, pc<=pc+4, -> REQ.
REQ-020 Consume: when if_valid=1 and stall=0, and no new response captured that cycle, if_valid<=0 and instruction<=NOP_INSN at next edge.
REQ-021 Stall: while stall=1, instruction, pc_data, if_valid SHALL hold; no new response is captured into a full buffer (guaranteed by REQ-018).
REQ-022 Redirect (redirect_en=1) SHALL take priority over every other event: pc<={redirect_pc[31:2],2'b00}, if_valid<=0, instruction<=NOP_INSN, regardless of stall.
REQ-023 Redirect in WAIT, or in REQ coinciding with handshake: discard<=1, state -> WAIT; the next imem_rvalid is dropped, discard<=0, -> REQ.
REQ-024 Redirect coinciding with imem_rvalid (discard=0): response dropped, -> REQ with new pc.
REQ-025 Redirect in REQ without handshake: request withdrawn; next cycle imem_addr = new pc (memory permits address change before acceptance).
REQ-026 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-027 Best-case throughput: one instruction per 2 cycles with 0-wait memory (handshake cycle + response cycle).

Reset
REQ-028 On reset_n=0 (asynchronously): pc=RESET_PC, state=REQ, if_valid=0, discard=0, instruction=NOP_INSN, pc_data=0.
REQ-029 imem_req SHALL be 0 while reset_n=0; first request at first edge after deassertion with imem_addr=RESET_PC.
REQ-030 Reset mid-WAIT abandons the request; instruction memory shares reset_n, so no stale response is expected.

Verification
REQ-031 Reset release, imem always ready, 1-cycle response, rdata=addr^32'hA5A5_0000 -> imem_addr 0,4,8..; pc_data/instruction pairs match; if_valid every second cycle.
REQ-032 stall=1 for 5 cycles while if_valid=1 at pc_data=8 -> outputs held, imem_req=0, if_id_wr_en=0; release -> next request addr 12.
REQ-033 redirect_en with redirect_pc=32'h0000_0103 while WAIT -> next rvalid dropped, following imem_addr=32'h0000_0100, if_valid=0 meanwhile.
REQ-034 redirect_en same cycle as imem_rvalid -> response not captured, instruction=NOP_INSN, next imem_addr=redirect target.
REQ-035 redirect to 32'hFFFF_FFFC -> fetches FFFF_FFFC then 0000_0000.
REQ-036 reset_n pulsed low mid-WAIT with stall=1 -> all outputs to reset values immediately, restart at RESET_PC.
